// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : regfile_sb
// Purpose  : Integer + floating-point architectural register file for the
//            RV64IMFD core, with a per-register busy scoreboard. Decode reads
//            operands, checks readiness and reserves destinations; writeback
//            stores results and releases busy bits.
// Revision : 1.0 - initial release
//
// Ports:
//   clk           in   clock
//   n_reset       in   asynchronous active-low reset
//   rs_dec        in   NUM_RD*AW packed source indices, port i at [i*AW +: AW]
//   rs_type_dec   in   NUM_RD bank select per read port (1 = float, 0 = int)
//   op_reg        out  NUM_RD*XLEN packed read data
//   op_rdy_dec    out  NUM_RD, 1 = source of port i not busy (or forwarded)
//   rsv_dec       in   reserve destination (sets busy)
//   rsv_rd_dec    in   AW destination index to reserve
//   rsv_type_dec  in   bank of the reserved destination
//   we_wb         in   2 writeback enables
//   rd_wb         in   2*AW writeback indices
//   type_wb       in   2 writeback banks
//   op_wb         in   2*XLEN writeback data
//   flush         in   synchronous clear of every busy bit
//   busy_any      out  OR of all busy bits
//
// Build option:
//   REGFILE_WB_BYPASS_EN - when defined, a writeback in the same cycle as a
//   matching read is forwarded to op_reg and marks that port ready.
// ============================================================================
module regfile_sb #(
    parameter int XLEN     = 64,
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 3,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic                   clk,
    input  logic                   n_reset,
    input  logic [NUM_RD*AW-1:0]   rs_dec,
    input  logic [NUM_RD-1:0]      rs_type_dec,
    output logic [NUM_RD*XLEN-1:0] op_reg,
    output logic [NUM_RD-1:0]      op_rdy_dec,
    input  logic                   rsv_dec,
    input  logic [AW-1:0]          rsv_rd_dec,
    input  logic                   rsv_type_dec,
    input  logic [1:0]             we_wb,
    input  logic [2*AW-1:0]        rd_wb,
    input  logic [1:0]             type_wb,
    input  logic [2*XLEN-1:0]      op_wb,
    input  logic                   flush,
    output logic                   busy_any
);

    // Register storage and scoreboard. Int entry 0 is never written and its
    // busy bit is never set, so x0 reads as zero and is always ready without
    // any special casing on the read side.
    logic [XLEN-1:0]     r_int_regs [NUM_REGS];
    logic [XLEN-1:0]     r_fp_regs  [NUM_REGS];
    logic [NUM_REGS-1:0] r_int_busy;
    logic [NUM_REGS-1:0] r_fp_busy;
    logic [NUM_REGS-1:0] w_int_busy_nxt;
    logic [NUM_REGS-1:0] w_fp_busy_nxt;

    // ------------------------------------------------------------------
    // Data writes. Port 1 is applied after port 0 so it wins when both
    // target the same bank and register.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_int_regs[r] <= '0;
                r_fp_regs[r]  <= '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (we_wb[k]) begin
                    if (type_wb[k]) begin
                        r_fp_regs[rd_wb[k*AW +: AW]] <= op_wb[k*XLEN +: XLEN];
                    end else if (rd_wb[k*AW +: AW] != '0) begin
                        r_int_regs[rd_wb[k*AW +: AW]] <= op_wb[k*XLEN +: XLEN];
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard next state. Ordering gives the priority: writeback
    // release, then reservation (a new producer outranks the retiring
    // one), then flush clears everything.
    // ------------------------------------------------------------------
    always_comb begin
        w_int_busy_nxt = r_int_busy;
        w_fp_busy_nxt  = r_fp_busy;
        for (int k = 0; k < 2; k++) begin
            if (we_wb[k]) begin
                if (type_wb[k]) begin
                    w_fp_busy_nxt[rd_wb[k*AW +: AW]] = 1'b0;
                end else begin
                    w_int_busy_nxt[rd_wb[k*AW +: AW]] = 1'b0;
                end
            end
        end
        if (rsv_dec) begin
            if (rsv_type_dec) begin
                w_fp_busy_nxt[rsv_rd_dec] = 1'b1;
            end else begin
                w_int_busy_nxt[rsv_rd_dec] = 1'b1;
            end
        end
        w_int_busy_nxt[0] = 1'b0;
        if (flush) begin
            w_int_busy_nxt = '0;
            w_fp_busy_nxt  = '0;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_int_busy <= '0;
            r_fp_busy  <= '0;
        end else begin
            r_int_busy <= w_int_busy_nxt;
            r_fp_busy  <= w_fp_busy_nxt;
        end
    end

    assign busy_any = (|r_int_busy) | (|r_fp_busy);

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd_port
        logic [AW-1:0]   w_idx;
        logic            w_is_fp;
        logic [XLEN-1:0] w_data;
        logic            w_busy;

        assign w_idx   = rs_dec[i*AW +: AW];
        assign w_is_fp = rs_type_dec[i];

        always_comb begin
            w_data = w_is_fp ? r_fp_regs[w_idx] : r_int_regs[w_idx];
            w_busy = w_is_fp ? r_fp_busy[w_idx] : r_int_busy[w_idx];
`ifdef REGFILE_WB_BYPASS_EN
            // Later port overrides earlier, matching write priority.
            for (int k = 0; k < 2; k++) begin
                if (we_wb[k] && (type_wb[k] == w_is_fp) &&
                    (rd_wb[k*AW +: AW] == w_idx) &&
                    (w_is_fp || (w_idx != '0))) begin
                    w_data = op_wb[k*XLEN +: XLEN];
                    w_busy = 1'b0;
                end
            end
`else
            // Reads see register state only; writes land next cycle.
`endif
        end

        assign op_reg[i*XLEN +: XLEN] = w_data;
        assign op_rdy_dec[i]          = ~w_busy;
    end

endmodule
`default_nettype wire
